// File: rtl/adder_vector_recorder.sv
// rtl/adder_vector_recorder.sv - exhaustive adder stimulus sweep and {a,b,cin,cout,s} vector recorder; optional self-check under ADDER_REC_CHECK_EN
module adder_vector_recorder #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  output logic                 dut_cin,
  input  logic [WIDTH-1:0]     dut_s,
  input  logic                 dut_cout,
  output logic [3*WIDTH+1:0]   vec_data,
  output logic                 vec_valid,
  input  logic                 vec_ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH+1:0]   vec_count,
  output logic [2*WIDTH+1:0]   error_count
);

  localparam int IW = 2*WIDTH + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_EMIT,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic [SW-1:0]   settle_cnt;
  logic            settle_last;
  logic            idx_last;
  logic            capture;

  // The sweep index is the only source of the adder operands, so they are
  // registered and change only when the index advances on entering APPLY.
  assign dut_a   = idx[IW-1:WIDTH+1];
  assign dut_b   = idx[WIDTH:1];
  assign dut_cin = idx[0];

  assign settle_last = (settle_cnt == SW'(SETTLE - 1));
  assign idx_last    = &idx;
  assign capture     = (state == S_APPLY) && settle_last;

  assign busy      = (state != S_IDLE);
  assign vec_valid = (state == S_EMIT);
  assign done      = (state == S_DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: settle, emit with backpressure, then a single done cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_APPLY;
      S_APPLY: if (settle_last) state_nxt = S_EMIT;
      S_EMIT:  if (vec_ready) state_nxt = idx_last ? S_DONE : S_APPLY;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sweep index, settle timer, captured word and accepted-vector count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      settle_cnt <= '0;
      vec_data   <= '0;
      vec_count  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx        <= '0;
            settle_cnt <= '0;
            vec_count  <= '0;
          end
        end
        S_APPLY: begin
          if (settle_last) begin
            settle_cnt <= '0;
            vec_data   <= {dut_a, dut_b, dut_cin, dut_cout, dut_s};
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_EMIT: begin
          if (vec_ready) begin
            vec_count <= vec_count + 1'b1;
            if (!idx_last) idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ADDER_REC_CHECK_EN
  logic [WIDTH:0] ref_sum;

  assign ref_sum = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};

  // Mismatch counter updates on the capture edge, i.e. as vec_valid rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_count <= '0;
    end else if ((state == S_IDLE) && start) begin
      error_count <= '0;
    end else if (capture && ({dut_cout, dut_s} != ref_sum)) begin
      error_count <= error_count + 1'b1;
    end
  end
`else
  assign error_count = '0;
`endif

endmodule

// File: tb/tb_adder_vector_recorder.sv
// tb/tb_adder_vector_recorder.sv - directed bench for adder_vector_recorder (SETTLE=1 and SETTLE=3 instances)
module tb_adder_vector_recorder;

  logic       clk;
  logic       rst_n;

  logic       start, vec_ready, stuck;
  logic [1:0] dut_a, dut_b, dut_s;
  logic       dut_cin, dut_cout;
  logic [7:0] vec_data;
  logic       vec_valid, busy, done;
  logic [5:0] vec_count, error_count;
  logic [2:0] sum1;

  logic       start3, ready3;
  logic [1:0] a3, b3, s3;
  logic       cin3, cout3;
  logic [7:0] data3;
  logic       valid3, busy3, done3;
  logic [5:0] cnt3, err3;
  logic [2:0] sum3;

  int checks = 0;
  int fails  = 0;
  logic [7:0] rec[$];

  adder_vector_recorder #(.WIDTH(2), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin),
    .dut_s(dut_s), .dut_cout(dut_cout),
    .vec_data(vec_data), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .busy(busy), .done(done), .vec_count(vec_count), .error_count(error_count)
  );

  adder_vector_recorder #(.WIDTH(2), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .dut_a(a3), .dut_b(b3), .dut_cin(cin3),
    .dut_s(s3), .dut_cout(cout3),
    .vec_data(data3), .vec_valid(valid3), .vec_ready(ready3),
    .busy(busy3), .done(done3), .vec_count(cnt3), .error_count(err3)
  );

  // Adder models: dut1 can have its carry-out stuck at 0
  assign sum1     = {1'b0, dut_a} + {1'b0, dut_b} + {2'b0, dut_cin};
  assign dut_s    = sum1[1:0];
  assign dut_cout = sum1[2] & ~stuck;
  assign sum3     = {1'b0, a3} + {1'b0, b3} + {2'b0, cin3};
  assign s3       = sum3[1:0];
  assign cout3    = sum3[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input int i, input bit stk);
    logic [4:0] v;
    logic [2:0] s;
    v = i[4:0];
    s = {1'b0, v[4:3]} + {1'b0, v[2:1]} + {2'b0, v[0]};
    if (stk) s[2] = 1'b0;
    return {v, s};
  endfunction

  // One sweep on dut1; mode 0 = ready held high, 1 = random ready
  task automatic sweep(input int mode, input int mid_at,
                       output int nwords, output int ncyc, output int ndone);
    logic [7:0] held;
    bit         stalled;
    held = '0; stalled = 0; ncyc = 0; ndone = 0;
    rec.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    for (int c = 0; c < 3000 && ndone == 0; c++) begin
      if (stalled) begin
        chk("stall_valid", {31'b0, vec_valid}, 32'd1);
        chk("stall_data", {24'b0, vec_data}, {24'b0, held});
      end
      start     = (c == mid_at);
      vec_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (done) ndone++;
      else if (busy) ncyc++;
      if (vec_valid && vec_ready) rec.push_back(vec_data);
      stalled = vec_valid && !vec_ready;
      held    = vec_data;
      @(negedge clk);
    end
    start     = 1'b0;
    vec_ready = 1'b1;
    nwords    = rec.size();
    chk("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  task automatic check_seq(input string tag, input bit stk);
    for (int i = 0; i < 32 && i < rec.size(); i++)
      chk(tag, {24'b0, rec[i]}, {24'b0, model(i, stk)});
  endtask

  initial begin
    int nw, nc, nd, run, exp_err;
    bit prev_busy, prev_valid;
    logic [4:0] prev_dut;

    rst_n = 1'b0; start = 1'b0; vec_ready = 1'b1; stuck = 1'b0;
    start3 = 1'b0; ready3 = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, vec_valid}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_data", {24'b0, vec_data}, 32'd0);
    chk("rst_dut", {27'b0, dut_a, dut_b, dut_cin}, 32'd0);
    chk("rst_counts", {20'b0, vec_count, error_count}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Golden sweep, ready held high
    sweep(0, -1, nw, nc, nd);
    chk("gold_words", nw, 32);
    chk("gold_cycles", nc, 64);
    chk("gold_done", nd, 1);
    chk("word1", {24'b0, rec[1]}, 32'h09);
    chk("word5", {24'b0, rec[5]}, 32'h2B);
    chk("word31", {24'b0, rec[31]}, 32'hFF);
    check_seq("gold_seq", 0);
    chk("gold_vec_count", {26'b0, vec_count}, 32'd32);
    chk("gold_err", {26'b0, error_count}, 32'd0);
    repeat (3) @(negedge clk);
    chk("idle_hold_count", {26'b0, vec_count}, 32'd32);
    chk("idle_busy", {31'b0, busy}, 32'd0);

    // Backpressure
    sweep(1, -1, nw, nc, nd);
    chk("bp_words", nw, 32);
    chk("bp_done", nd, 1);
    check_seq("bp_seq", 0);
    chk("bp_vec_count", {26'b0, vec_count}, 32'd32);

    // Carry-out stuck at 0
`ifdef ADDER_REC_CHECK_EN
    exp_err = 16;
`else
    exp_err = 0;
`endif
    stuck = 1'b1;
    sweep(0, -1, nw, nc, nd);
    stuck = 1'b0;
    chk("stuck_words", nw, 32);
    check_seq("stuck_seq", 1);
    chk("stuck_err", {26'b0, error_count}, exp_err);

    // Start pulsed mid-sweep is ignored
    sweep(0, 20, nw, nc, nd);
    chk("mid_words", nw, 32);
    chk("mid_cycles", nc, 64);
    chk("mid_done", nd, 1);
    check_seq("mid_seq", 0);

    // Reset during vector 10
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    nd = 0;
    for (int c = 0; c < 200; c++) begin
      if (vec_valid && vec_count == 6'd10) break;
      if (done) nd++;
      @(negedge clk);
    end
    chk("rst_reached_v10", {26'b0, vec_count}, 32'd10);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_valid", {31'b0, vec_valid}, 32'd0);
    chk("arst_data", {24'b0, vec_data}, 32'd0);
    chk("arst_dut", {27'b0, dut_a, dut_b, dut_cin}, 32'd0);
    chk("arst_count", {26'b0, vec_count}, 32'd0);
    @(negedge clk);
    if (done) nd++;
    rst_n = 1'b1;
    @(negedge clk);
    if (done) nd++;
    chk("arst_no_done", nd, 0);
    chk("arst_idle", {31'b0, busy}, 32'd0);
    sweep(0, -1, nw, nc, nd);
    chk("restart_word0", {24'b0, rec[0]}, 32'h00);
    chk("restart_words", nw, 32);

    // SETTLE=3 instance
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    run = 0; nw = 0; nc = 0; nd = 0;
    prev_busy = 0; prev_valid = 0; prev_dut = '0;
    for (int c = 0; c < 1000 && nd == 0; c++) begin
      if (done3) nd++;
      else if (busy3) nc++;
      if (busy3 && !valid3 && !done3) begin
        if (!prev_busy || prev_valid || ({a3, b3, cin3} != prev_dut)) run = 1;
        else run++;
      end
      if (valid3 && !prev_valid) begin
        chk("s3_hold", run, 3);
        chk("s3_word", {24'b0, data3}, {24'b0, model(nw, 0)});
        nw++;
      end
      prev_busy  = busy3;
      prev_valid = valid3;
      prev_dut   = {a3, b3, cin3};
      @(negedge clk);
    end
    chk("s3_words", nw, 32);
    chk("s3_cycles", nc, 128);
    chk("s3_done", nd, 1);
    chk("s3_count", {26'b0, cnt3}, 32'd32);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
